// File: rtl/dkong3_snd_cmd.sv
// Sound-command mailbox: captures main-CPU writes to CMD_BASE page, one command per sub-CPU channel,
// plus a stretched sub-CPU reset. Define DKONG3_CMD_FIFO_EN for per-channel FIFOs instead of latches.
module dkong3_snd_cmd #(
    parameter logic [7:0]  CMD_BASE   = 8'h7C,
    parameter int unsigned RESET_HOLD = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        I_CLK_12M,
    input  logic        I_RESET,
    input  logic [15:0] I_MCPU_A,
    input  logic [7:0]  I_MCPU_D,
    input  logic        I_MCPU_WRn,
    input  logic        I_SUB_RESETn,
    input  logic        I_SUB0_RDn,
    input  logic        I_SUB1_RDn,
    output logic [7:0]  O_SUB0_D,
    output logic [7:0]  O_SUB1_D,
    output logic [1:0]  O_PEND,
    output logic [1:0]  O_OVF,
    output logic        O_SUB_RESET
);
    localparam int unsigned CW = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN} st_e;

    st_e           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sub_rst_q, sub_rst_d;

    logic [8:0]    a_q;
    logic [7:0]    d_q;
    logic          wrn_q;
    logic [1:0]    rdn_q;
    logic [1:0]    rdn_c;
    logic          wr_ev_c;
    logic [1:0]    rd_ev_c;

    logic [7:0]    sub_d [2];
    logic [1:0]    pend;
    logic [1:0]    ovf;

    logic          unused_cfg;
    assign unused_cfg = ^{I_MCPU_A[6:0], 5'(FIFO_DEPTH)};

    assign rdn_c = {I_SUB1_RDn, I_SUB0_RDn};

    // Bus capture and strobe edge detection
    always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
        if (I_RESET) begin
            a_q   <= '0;
            d_q   <= '0;
            wrn_q <= 1'b1;
            rdn_q <= 2'b11;
        end else begin
            a_q   <= I_MCPU_A[15:7];
            d_q   <= I_MCPU_D;
            wrn_q <= I_MCPU_WRn;
            rdn_q <= rdn_c;
        end
    end

    // Strobe rising edges; everything is frozen while the sub stage is in reset
    assign wr_ev_c = !wrn_q && I_MCPU_WRn && (a_q[8:1] == CMD_BASE) && !sub_rst_q;
    assign rd_ev_c = ~rdn_q & rdn_c & {2{!sub_rst_q}};

    always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
        if (I_RESET) begin
            st_q      <= ST_ASSERT;
            cnt_q     <= CW'(RESET_HOLD);
            sub_rst_q <= 1'b1;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            sub_rst_q <= sub_rst_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_ASSERT: begin
                cnt_d = CW'(RESET_HOLD);
                if (I_SUB_RESETn) st_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!I_SUB_RESETn) begin
                    st_d  = ST_ASSERT;
                    cnt_d = CW'(RESET_HOLD);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_d == '0) st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!I_SUB_RESETn) begin
                    st_d  = ST_ASSERT;
                    cnt_d = CW'(RESET_HOLD);
                end
            end
            default: st_d = ST_ASSERT;
        endcase
        sub_rst_d = (st_d != ST_RUN);
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic       wr_c, rd_c;
        logic [7:0] dat_q, dat_d;
        logic       pend_q, pend_d;
        logic       ovf_q, ovf_d;

        assign wr_c = wr_ev_c && (a_q[0] == 1'(ch));
        assign rd_c = rd_ev_c[ch];

`ifdef DKONG3_CMD_FIFO_EN
        localparam int unsigned AW = $clog2(FIFO_DEPTH);
        localparam int unsigned PW = AW + 1;

        logic [7:0]  mem_q [FIFO_DEPTH];
        logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, rp_nx;
        logic        empty_c, full_c, pop_c, push_c;

        assign empty_c = (wp_q == rp_q);
        assign full_c  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        assign pop_c   = rd_c && !empty_c;
        assign push_c  = wr_c && (!full_c || pop_c);
        assign rp_nx   = rp_q + PW'(1);

        // Pop-then-push; head register tracks the oldest live entry
        always_comb begin
            wp_d  = wp_q;
            rp_d  = rp_q;
            dat_d = dat_q;
            ovf_d = ovf_q;
            if (sub_rst_q) begin
                wp_d  = '0;
                rp_d  = '0;
                dat_d = '0;
            end else begin
                if (pop_c)           rp_d  = rp_nx;
                if (push_c)          wp_d  = wp_q + PW'(1);
                if (wr_c && !push_c) ovf_d = 1'b1;
                if (pop_c) begin
                    if (rp_nx != wp_q) dat_d = mem_q[rp_nx[AW-1:0]];
                    else if (push_c)   dat_d = d_q;
                end else if (push_c && empty_c) begin
                    dat_d = d_q;
                end
            end
            pend_d = (wp_d != rp_d);
        end

        always_ff @(posedge I_CLK_12M) begin
            if (push_c) mem_q[wp_q[AW-1:0]] <= d_q;
        end

        always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
            if (I_RESET) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                wp_q <= wp_d;
                rp_q <= rp_d;
            end
        end
`else
        // Single latch: a write always wins over a concurrent read
        always_comb begin
            dat_d  = dat_q;
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (sub_rst_q) begin
                dat_d  = '0;
                pend_d = 1'b0;
            end else if (wr_c) begin
                dat_d  = d_q;
                pend_d = 1'b1;
                if (pend_q && !rd_c) ovf_d = 1'b1;
            end else if (rd_c) begin
                pend_d = 1'b0;
            end
        end
`endif

        always_ff @(posedge I_CLK_12M or posedge I_RESET) begin
            if (I_RESET) begin
                dat_q  <= '0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                dat_q  <= dat_d;
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
            end
        end

        assign sub_d[ch] = dat_q;
        assign pend[ch]  = pend_q;
        assign ovf[ch]   = ovf_q;
    end

    assign O_SUB0_D    = sub_d[0];
    assign O_SUB1_D    = sub_d[1];
    assign O_PEND      = pend;
    assign O_OVF       = ovf;
    assign O_SUB_RESET = sub_rst_q;

endmodule

// File: tb/tb_dkong3_snd_cmd.sv
// Scoreboard bench for dkong3_snd_cmd: queue model of each channel's mailbox contents.
module tb_dkong3_snd_cmd;
    localparam int          HOLD = 16;
    localparam logic [7:0]  BASE = 8'h7C;
`ifdef DKONG3_CMD_FIFO_EN
    localparam int          DEPTH = 4;
`else
    localparam int          DEPTH = 1;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [7:0]  D;
    logic        WRn;
    logic        SUB_RSTn;
    logic        RD0n, RD1n;
    logic [7:0]  O_SUB0_D, O_SUB1_D;
    logic [1:0]  O_PEND, O_OVF;
    logic        O_SUB_RESET;

    logic [7:0]  mq [2][$];
    logic [7:0]  mhead [2];
    logic [1:0]  movf;
    bit          m_rst;

    int n_cmp = 0;
    int n_err = 0;

    dkong3_snd_cmd dut (
        .I_CLK_12M    (clk),
        .I_RESET      (rst),
        .I_MCPU_A     (A),
        .I_MCPU_D     (D),
        .I_MCPU_WRn   (WRn),
        .I_SUB_RESETn (SUB_RSTn),
        .I_SUB0_RDn   (RD0n),
        .I_SUB1_RDn   (RD1n),
        .O_SUB0_D     (O_SUB0_D),
        .O_SUB1_D     (O_SUB1_D),
        .O_PEND       (O_PEND),
        .O_OVF        (O_OVF),
        .O_SUB_RESET  (O_SUB_RESET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] p;
        p[0] = (mq[0].size() != 0);
        p[1] = (mq[1].size() != 0);
        check_eq({tag, ".d0"},   16'(O_SUB0_D), 16'(mhead[0]));
        check_eq({tag, ".d1"},   16'(O_SUB1_D), 16'(mhead[1]));
        check_eq({tag, ".pend"}, 16'(O_PEND),   16'(p));
        check_eq({tag, ".ovf"},  16'(O_OVF),    16'(movf));
    endtask

    // Model of one main-CPU write, optionally with a same-cycle read on the target channel
    task automatic model_wr(input logic [15:0] a, input logic [7:0] d, input bit rd, input logic [7:0] seen);
        int         ch;
        logic [7:0] pv;
        ch = a[7] ? 1 : 0;
        if (m_rst) return;
        if (rd && mq[ch].size() > 0) begin
            pv = mq[ch].pop_front();
            check_eq("rdwr_data", 16'(seen), 16'(pv));
        end
        if (a[15:8] == BASE) begin
            if (mq[ch].size() < DEPTH) begin
                mq[ch].push_back(d);
            end else begin
                if (DEPTH == 1) mq[ch][0] = d;
                movf[ch] = 1'b1;
            end
        end
        if (mq[ch].size() > 0) mhead[ch] = mq[ch][0];
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input bit rd);
        int         ch;
        logic [7:0] seen;
        ch = a[7] ? 1 : 0;
        @(negedge clk);
        A = a; D = d; WRn = 1'b0;
        if (rd) begin
            if (ch == 0) RD0n = 1'b0; else RD1n = 1'b0;
        end
        @(negedge clk);
        seen = (ch == 1) ? O_SUB1_D : O_SUB0_D;
        check_eq("wr_pre", 16'(seen), 16'(mhead[ch]));
        WRn = 1'b1; RD0n = 1'b1; RD1n = 1'b1;
        model_wr(a, d, rd, seen);
        @(posedge clk); #1;
        check_all("wr");
    endtask

    task automatic sub_rd(input int ch);
        logic [7:0] seen, pv;
        @(negedge clk);
        if (ch == 0) RD0n = 1'b0; else RD1n = 1'b0;
        @(negedge clk);
        seen = (ch == 1) ? O_SUB1_D : O_SUB0_D;
        RD0n = 1'b1; RD1n = 1'b1;
        if (!m_rst && mq[ch].size() > 0) begin
            pv = mq[ch].pop_front();
            check_eq("rd_data", 16'(seen), 16'(pv));
            if (mq[ch].size() > 0) mhead[ch] = mq[ch][0];
        end
        @(posedge clk); #1;
        check_all("rd");
    endtask

    initial begin
        int n;
        rst = 1'b1; A = '0; D = '0; WRn = 1'b1; SUB_RSTn = 1'b0; RD0n = 1'b1; RD1n = 1'b1;
        mhead[0] = 8'h00; mhead[1] = 8'h00; movf = 2'b00; m_rst = 1'b1;
        #2;
        check_all("reset");
        check_eq("reset.srst", 16'(O_SUB_RESET), 16'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("assert.srst", 16'(O_SUB_RESET), 16'd1);
        check_all("assert");

        // Release timing: falls on the HOLD-th edge after the request is first seen high
        @(negedge clk);
        SUB_RSTn = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            @(posedge clk); #1;
            check_eq("srst_release", 16'(O_SUB_RESET), (i >= HOLD) ? 16'd0 : 16'd1);
        end
        m_rst = 1'b0;
        check_all("run");

        cpu_wr(16'h7C00, 8'h3A, 1'b0);
        cpu_wr(16'h7C80, 8'h5C, 1'b0);

`ifdef DKONG3_CMD_FIFO_EN
        sub_rd(0);
        sub_rd(1);
        for (int i = 1; i <= 5; i++) cpu_wr(16'h7C00, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) sub_rd(0);
        for (int i = 0; i < 4; i++) cpu_wr(16'h7C80, 8'(8'hB0 + i), 1'b0);
        cpu_wr(16'h7C80, 8'hB4, 1'b1);
        for (int i = 0; i < 4; i++) sub_rd(1);
`else
        sub_rd(0);
        cpu_wr(16'h7C00, 8'h11, 1'b0);
        cpu_wr(16'h7C00, 8'h22, 1'b0);
        sub_rd(0);
        sub_rd(0);
        cpu_wr(16'h7C80, 8'h66, 1'b1);
        sub_rd(1);
`endif

        cpu_wr(16'h7D00, 8'hAA, 1'b0);
        cpu_wr(16'h7B80, 8'hBB, 1'b0);

        cpu_wr(16'h7C00, 8'h44, 1'b0);
        cpu_wr(16'h7C80, 8'h55, 1'b0);

        // One-cycle sub reset request flushes both channels and blocks writes during HOLD
        @(negedge clk);
        SUB_RSTn = 1'b0;
        @(negedge clk);
        SUB_RSTn = 1'b1;
        m_rst = 1'b1;
        mq[0].delete();
        mq[1].delete();
        mhead[0] = 8'h00;
        mhead[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all("flush");
        check_eq("flush.srst", 16'(O_SUB_RESET), 16'd1);
        cpu_wr(16'h7C00, 8'h77, 1'b0);
        sub_rd(1);

        n = 0;
        while (O_SUB_RESET && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rerun.srst", 16'(O_SUB_RESET), 16'd0);
        m_rst = 1'b0;
        cpu_wr(16'h7C80, 8'h99, 1'b0);
        sub_rd(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
